// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with registered reads and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN for write-to-read forwarding and busy masking in the WB cycle.
module regfile_sb #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
)(
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rsel0,
  input  logic [ADDR_W-1:0]    rsel1,
  output logic [WIDTH-1:0]     read0,
  output logic [WIDTH-1:0]     read1,
  output logic                 rvalid,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wsel,
  input  logic [WIDTH-1:0]     w,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_sel,
  output logic                 busy0,
  output logic                 busy1,
  output logic [2**ADDR_W-1:0] pend
);
  localparam int DEPTH = 2**ADDR_W;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_set, w_clr;
  logic [WIDTH-1:0] w_rd0, w_rd1;
  logic             w_wr, w_hit0, w_hit1;
  always_comb begin
    w_wr   = we && !(ZERO_REG != 0 && wsel == '0);
    w_hit0 = we && wsel == rsel0;
    w_hit1 = we && wsel == rsel1;
    w_set  = rsv_en ? DEPTH'(1) << rsv_sel : '0;
    w_set[0] = w_set[0] && ZERO_REG == 0;
    w_clr  = we ? DEPTH'(1) << wsel : '0;
`ifdef REGFILE_BYPASS_EN
    w_rd0  = (w_wr && w_hit0) ? w : r_mem[rsel0];
    w_rd1  = (w_wr && w_hit1) ? w : r_mem[rsel1];
    busy0  = r_pend[rsel0] && !w_hit0;
    busy1  = r_pend[rsel1] && !w_hit1;
`else
    w_rd0  = r_mem[rsel0];
    w_rd1  = r_mem[rsel1];
    busy0  = r_pend[rsel0];
    busy1  = r_pend[rsel1];
`endif
  end
  // a new reservation outranks the older writer's clear on the same register
  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
      read0  <= '0;
      read1  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (w_wr) r_mem[wsel] <= w;
      r_pend <= w_set | (r_pend & ~w_clr);
      rvalid <= rd_en;
      if (rd_en) begin
        read0 <= w_rd0;
        read1 <= w_rd1;
      end
    end
  end
  assign pend = r_pend;
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file with 2 read ports and 1 write port for the IF/ID/EXE/MEM/WB pipeline.
- Generalises the two-entry, 8-bit file to WIDTH x 2**ADDR_W entries.
- Adds synchronous reset, registered reads with a valid strobe, and independent read and write in the same cycle.
- Adds a pending-write scoreboard: ID uses it to stall on RAW hazards until WB writes the register.

Parameters:
- WIDTH, 8, data width of each register.
- ADDR_W, 2, select width. DEPTH = 2**ADDR_W entries (derived localparam).
- ZERO_REG, 0, if 1 then register 0 reads as 0 and ignores writes and reservations.

Ports:
- sysclk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_en  input  1  capture both read ports this cycle.
- rsel0  input  ADDR_W  read port 0 select.
- rsel1  input  ADDR_W  read port 1 select.
- read0  output  WIDTH  registered read data, port 0.
- read1  output  WIDTH  registered read data, port 1.
- rvalid  output  1  one-cycle pulse: read0/read1 updated by a rd_en in the previous cycle.
- we  input  1  write enable (WB stage).
- wsel  input  ADDR_W  write select.
- w  input  WIDTH  write data.
- rsv_en  input  1  mark register rsv_sel pending (ID issues an instruction that writes it).
- rsv_sel  input  ADDR_W  register to reserve.
- busy0  output  1  combinational: rsel0's register has a pending write.
- busy1  output  1  combinational: rsel1's register has a pending write.
- pend  output  DEPTH  pending-bit vector, bit i = register i.

Behaviour:
- Reset is synchronous and active-high and has priority over every other input. On reset:
  - all registers = 0, pend = 0;
  - read0 = read1 = 0, rvalid = 0.
- Write: on an edge with we=1, reg[wsel] <= w.
  - Exception: wsel=0 with ZERO_REG=1 is discarded.
  - we=0 leaves all registers unchanged.
- Read: on an edge with rd_en=1:
  - read0 <= reg[rsel0], read1 <= reg[rsel1], rvalid <= 1.
  - Latency is 1 cycle.
- With rd_en=0: read0/read1 hold their values and rvalid <= 0.
- Read and write are independent; both may happen in the same cycle. With rsel==wsel in that cycle, see Optional Feature.
- Both ports may select the same register; each returns the same value.
- Scoreboard, per register i, evaluated each edge:
  - set = rsv_en && rsv_sel==i;
  - clr = we && wsel==i;
  - pend[i] <= set ? 1 : (clr ? 0 : pend[i]).
  - Set and clear on the same register in the same cycle: set wins. The new instruction's reservation survives the older instruction's writeback.
  - Reserving an already-pending register leaves it pending. There is no count; a single outstanding writer per register is required.
  - A write to a non-pending register is legal and leaves pend[i] = 0.
- busy0 = pend[rsel0], busy1 = pend[rsel1], before the write-bypass masking given under Optional Feature.
- ZERO_REG=1: pend[0] is held at 0, busy* is 0 for select 0, read* of register 0 is 0.
- Reset asserted mid-operation (pending bits set, read in flight): everything clears on that edge. No write completes on that edge.
- Selects are always in range because DEPTH = 2**ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read captured in the same cycle as a write to the same register returns w (write-then-read forwarding).
  - busyN is forced to 0 when we=1 and wsel==rselN, so ID can issue in the WB cycle.
  - The forwarded w is ignored for register 0 when ZERO_REG=1.
- Undefined:
  - The read returns the pre-write value.
  - busyN = pend[rselN] unmasked; ID stalls one extra cycle.

Test Plan:
- Reset then read: assert reset 1 cycle; then rd_en=1, rsel0=2, rsel1=3 -> next cycle rvalid=1, read0=0, read1=0, pend=0.
- Write/read all: WIDTH=8, write 0x11,0x22,0x33,0x44 to regs 0..3; then rd_en, rsel0=1, rsel1=3 -> read0=0x22, read1=0x44 after 1 cycle; rvalid pulses exactly 1 cycle; outputs hold while rd_en=0.
- Same-cycle read/write: reg2=0x33; we=1, wsel=2, w=0xA5, rd_en=1, rsel0=2 -> read0=0xA5 with REGFILE_BYPASS_EN defined, 0x33 without; next read returns 0xA5 either way.
- Scoreboard set/clear:
  - rsv_en, rsv_sel=1 -> pend=4'b0010, busy0=1 for rsel0=1.
  - Later we, wsel=1 -> pend=0.
  - Same cycle rsv_en/rsv_sel=1 and we/wsel=1 -> pend[1] stays 1.
- ZERO_REG=1: write 0xFF to reg0 and rsv_en, rsv_sel=0 -> read0=0, pend[0]=0, busy0=0 for rsel0=0.
- Mid-operation reset: pend=4'b1010, regs nonzero, rd_en=1 and we=1 in the same cycle as reset -> next cycle pend=0, read0=read1=0, rvalid=0, subsequent reads all return 0.
